// File: rtl/zx_mem_pkg.sv
// zx_mem_pkg: shared boot-state enum and bus constants; CLEAR state exists only with BOOT_CLEAR_EN
`timescale 1ns/1ps
package zx_mem_pkg;

    localparam int SDR_AW = 22;
    localparam int MEM_AW = 19;

    // Strobe triples are ordered {rf, rd, wr}, all active-low
    localparam logic [2:0] STRB_IDLE = 3'b111;
    localparam logic [2:0] STRB_WR   = 3'b110;
    localparam logic [2:0] STRB_RF   = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WRITE,
        RFSH,
`ifdef BOOT_CLEAR_EN
        CLEAR,
`endif
        DONE
    } bootState_t;

endpackage

// File: rtl/boot_rfsh_cnt.sv
// boot_rfsh_cnt: modulo-PERIOD count of boot write slots, flags when a refresh is due
`timescale 1ns/1ps
module boot_rfsh_cnt #(
    parameter int PERIOD = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic adv,
    input  logic clr,
    output logic due
);

    localparam int W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] rc;

    // Count write slots, wrapping at PERIOD; the refresh slot also clears it
    always_ff @(posedge clock or posedge reset)
        if (reset) rc <= '0;
        else if (clr) rc <= '0;
        else if (adv) rc <= due ? '0 : rc + 1'b1;

    assign due = rc == LAST;

endmodule

// File: rtl/sdram_boot_arb.sv
// sdram_boot_arb: copies boot ROM into SDRAM with refresh, then passes the CPU bus through (BOOT_CLEAR_EN adds a zero-fill pass)
`timescale 1ns/1ps
module sdram_boot_arb
    import zx_mem_pkg::*;
#(
    parameter int ROM_BYTES   = 32768,
    parameter int RFSH_PERIOD = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              ready,
    input  logic              memRf,
    input  logic              memRd,
    input  logic              memWr,
    input  logic [MEM_AW-1:0] memA,
    input  logic [7:0]        memQ,
    output logic [14:0]       romA,
    input  logic [7:0]        romQ,
    output logic              sdrRf,
    output logic              sdrRd,
    output logic              sdrWr,
    output logic [SDR_AW-1:0] sdrA,
    output logic [15:0]       sdrD,
    output logic              init
);

    localparam logic [MEM_AW-1:0] ROM_LAST = MEM_AW'(ROM_BYTES - 1);
`ifdef BOOT_CLEAR_EN
    localparam logic [MEM_AW-1:0] MEM_LAST = '1;
    localparam bootState_t AFTER_ROM = CLEAR;
`else
    localparam bootState_t AFTER_ROM = DONE;
`endif

    bootState_t        state, nextState, pend, nextPend;
    logic [MEM_AW-1:0] cnt, nextCnt;
    logic [2:0]        strb, nextStrb;
    logic [15:0]       bootD, nextD;
    logic              rcAdv, rcClr, rcDue, nextWr;

    boot_rfsh_cnt #(.PERIOD(RFSH_PERIOD)) rfshCnt (
        .clock(clock),
        .reset(reset),
        .adv  (ce & rcAdv),
        .clr  (ce & rcClr),
        .due  (rcDue)
    );

    // Boot state, address counter and registered strobes advance once per slot
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            pend  <= IDLE;
            cnt   <= '0;
            strb  <= STRB_IDLE;
            bootD <= '0;
        end else if (ce) begin
            state <= nextState;
            pend  <= nextPend;
            cnt   <= nextCnt;
            strb  <= nextStrb;
            bootD <= nextD;
        end

    // Next slot: pick the phase, remembering where to resume after a refresh slot
    always_comb begin
        nextState = state;
        nextPend  = pend;
        nextCnt   = cnt;
        rcAdv     = 1'b0;
        rcClr     = 1'b0;
        case (state)
            IDLE:  nextState = ready ? FETCH : IDLE;
            FETCH: nextState = WRITE;
            WRITE: begin
                nextCnt   = cnt + 1'b1;
                rcAdv     = 1'b1;
                nextPend  = (cnt == ROM_LAST) ? AFTER_ROM : FETCH;
                nextState = rcDue ? RFSH : nextPend;
            end
`ifdef BOOT_CLEAR_EN
            CLEAR: begin
                nextCnt   = cnt + 1'b1;
                rcAdv     = 1'b1;
                nextPend  = (cnt == MEM_LAST) ? DONE : CLEAR;
                nextState = rcDue ? RFSH : nextPend;
            end
`endif
            RFSH: begin
                rcClr     = 1'b1;
                nextState = pend;
            end
            default: nextState = state;
        endcase
`ifdef BOOT_CLEAR_EN
        nextWr   = nextState == WRITE || nextState == CLEAR;
`else
        nextWr   = nextState == WRITE;
`endif
        nextStrb = nextWr ? STRB_WR : (nextState == RFSH) ? STRB_RF : STRB_IDLE;
        nextD    = (nextState == WRITE) ? {2{romQ}} : 16'h0000;
    end

    assign init = state == DONE;
    assign romA = cnt[14:0];
    assign {sdrRf, sdrRd, sdrWr} = init ? {~memRf, ~memRd, ~(memWr & (memA[18] | memA[17]))} : strb;
    assign sdrA = init ? {3'b000, memA} : {3'b000, cnt};
    assign sdrD = init ? {2{memQ}} : bootD;

endmodule

// File: tb/tb_sdram_boot_arb.sv
// tb_sdram_boot_arb: directed and table-driven checks of boot copy, refresh insertion, reset and pass-through
`timescale 1ns/1ps
module tb_sdram_boot_arb;

    localparam int RB = 1024;
    localparam int RP = 64;
    localparam int BUDGET = 2 * RB + RB / RP + 8;

    logic        clock = 1'b0, reset = 1'b1, ce = 1'b0, ready = 1'b0;
    logic        memRf = 1'b0, memRd = 1'b0, memWr = 1'b0;
    logic [18:0] memA = '0;
    logic [7:0]  memQ = '0;
    logic [14:0] romA;
    logic [7:0]  romQ = '0;
    logic        sdrRf, sdrRd, sdrWr, init;
    logic [21:0] sdrA;
    logic [15:0] sdrD;
    logic [7:0]  rom [RB];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        rf, rd, wr;
        logic [18:0] a;
        logic [7:0]  q;
        logic [2:0]  eStrb;
        logic [21:0] eA;
        logic [15:0] eD;
    } passVec_t;

    passVec_t vecs [8];

    sdram_boot_arb #(.ROM_BYTES(RB), .RFSH_PERIOD(RP)) dut (
        .clock(clock), .reset(reset), .ce(ce), .ready(ready),
        .memRf(memRf), .memRd(memRd), .memWr(memWr), .memA(memA), .memQ(memQ),
        .romA(romA), .romQ(romQ),
        .sdrRf(sdrRf), .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrA(sdrA), .sdrD(sdrD),
        .init(init)
    );

    always #5 clock = ~clock;

    // Boot RAM: registered read every clock, so data is ready well before the next slot
    always @(posedge clock) romQ <= rom[romA[9:0]];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic slot();
        @(negedge clock) ce = 1'b1;
        @(negedge clock) ce = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string name);
        check(name, {sdrRf, sdrRd, sdrWr, sdrA, sdrD, romA, init}, {3'b111, 22'h0, 16'h0, 15'h0, 1'b0});
    endtask

    task automatic runBoot();
        int slots = 0, expAddr = 0, wrSince = 0, rfCnt = 0, firstA = -1;
        int eAddr = 0, eData = 0, eRom = 0, eSpace = 0, eOvl = 0;
        slot();
        while (!init && slots < BUDGET) begin
            slot();
            slots++;
            if (!init) begin
                if (romA !== 15'(expAddr)) eRom++;
                if ($countones(~{sdrRf, sdrRd, sdrWr}) > 1 || !sdrRd) eOvl++;
                if (!sdrWr) begin
                    if (firstA < 0) firstA = int'(sdrA);
                    if (sdrA !== 22'(expAddr)) eAddr++;
                    if (sdrD !== {2{rom[expAddr % RB]}}) eData++;
                    expAddr++;
                    wrSince++;
                end
                if (!sdrRf) begin
                    if (wrSince != RP) eSpace++;
                    wrSince = 0;
                    rfCnt++;
                end
            end
        end
        check("bootSlots", 64'(slots), 64'(2 * RB + RB / RP));
        check("initHigh", {63'h0, init}, 64'h1);
        check("firstWriteAddr", 64'(firstA), 64'h0);
        check("writeCount", 64'(expAddr), 64'(RB));
        check("writeAddrErrors", 64'(eAddr), 64'h0);
        check("writeDataErrors", 64'(eData), 64'h0);
        check("romAddrErrors", 64'(eRom), 64'h0);
        check("refreshCount", 64'(rfCnt), 64'(RB / RP));
        check("refreshSpacingErrors", 64'(eSpace), 64'h0);
        check("strobeOverlapErrors", 64'(eOvl), 64'h0);
    endtask

    initial begin
        int eStrb = 0, eRom = 0;
        for (int i = 0; i < RB; i++) rom[i] = 8'((i * 37) ^ (i >> 4));
        vecs[0] = '{1'b0, 1'b0, 1'b1, 19'h0A000, 8'h5A, 3'b111, 22'h00A000, 16'h5A5A};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 19'h20000, 8'hC3, 3'b110, 22'h020000, 16'hC3C3};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 19'h12345, 8'h01, 3'b101, 22'h012345, 16'h0101};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 19'h7FFFF, 8'hFF, 3'b011, 22'h07FFFF, 16'hFFFF};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 19'h40000, 8'h80, 3'b110, 22'h040000, 16'h8080};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 19'h1FFFF, 8'h00, 3'b111, 22'h01FFFF, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 19'h60000, 8'h3C, 3'b000, 22'h060000, 16'h3C3C};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 19'h60000, 8'h3C, 3'b111, 22'h060000, 16'h3C3C};

        repeat (3) @(negedge clock);
        checkResetOutputs("resetValues");
        reset = 1'b0;

        memRf = 1'b1;
        memRd = 1'b1;
        memWr = 1'b1;
        memA  = 19'h20000;
        for (int i = 0; i < 500; i++) begin
            slot();
            if (!(sdrRf & sdrRd & sdrWr)) eStrb++;
            if (romA !== 15'h0) eRom++;
        end
        check("notReadyStrobes", 64'(eStrb), 64'h0);
        check("notReadyRomA", 64'(eRom), 64'h0);
        check("notReadyInit", {63'h0, init}, 64'h0);
        memRf = 1'b0;
        memRd = 1'b0;
        memWr = 1'b0;
        memA  = '0;

        ready = 1'b1;
        for (int i = 0; i < 1000; i++) slot();
        check("slot1000Fetch", {49'h0, sdrRf, sdrRd, sdrWr, romA}, {49'h0, 3'b111, 15'd496});
        reset = 1'b1;
        #1;
        checkResetOutputs("asyncResetMidBoot");
        @(negedge clock) reset = 1'b0;

        runBoot();

        for (int i = 0; i < 8; i++) begin
            memRf = vecs[i].rf;
            memRd = vecs[i].rd;
            memWr = vecs[i].wr;
            memA  = vecs[i].a;
            memQ  = vecs[i].q;
            #1;
            check($sformatf("pass%0d", i), {23'h0, sdrRf, sdrRd, sdrWr, sdrA, sdrD},
                  {23'h0, vecs[i].eStrb, vecs[i].eA, vecs[i].eD});
            @(negedge clock);
        end

        slot();
        check("doneHeld", {63'h0, init}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
